// File: rtl/pong_match_ctrl.sv
// Match controller for the ping-pong game.
// Tracks the serve/play/end state, both scores, the frame timer, serve timing and win detection.
// It emits registered one-clock pulses for serve launch and for each point scored.
module pong_match_ctrl #(
  parameter int unsigned X_W           = 10,
  parameter int unsigned LEFT_GOAL     = 150,
  parameter int unsigned RIGHT_GOAL    = 490,
  parameter int unsigned SCORE_W       = 4,
  parameter int unsigned WIN_SCORE     = 11,
  parameter int unsigned WIN_BY_TWO    = 1,
  parameter int unsigned TMR_W         = 8,
  parameter int unsigned SERVE_TIMEOUT = 60,
  parameter int unsigned END_HOLD      = 120
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic               i_p1l,
  input  logic               i_p1r,
  input  logic               i_p2l,
  input  logic               i_p2r,
  input  logic [X_W-1:0]     i_ball_x,
  output logic [1:0]         o_game_state,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score,
  output logic               o_serve_launch,
  output logic               o_point_p1,
  output logic               o_point_p2,
  output logic [1:0]         o_winner,
  output logic [TMR_W-1:0]   o_frame_timer
);

  typedef enum logic [1:0] {
    StP1Serve = 2'd0,
    StP2Serve = 2'd1,
    StPlay    = 2'd2,
    StEnd     = 2'd3
  } state_e;

  localparam logic [X_W-1:0]     LeftGoal  = X_W'(LEFT_GOAL);
  localparam logic [X_W-1:0]     RightGoal = X_W'(RIGHT_GOAL);
  localparam logic [SCORE_W-1:0] ScoreMax  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);
  localparam logic [SCORE_W:0]   ScoreTwo  = (SCORE_W + 1)'(2);
  localparam logic [SCORE_W:0]   WinScore  = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [TMR_W-1:0]   TmrMax    = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0]   TmrOne    = TMR_W'(1);
  localparam logic [TMR_W-1:0]   ServeLast = TMR_W'(SERVE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   EndHold   = TMR_W'(END_HOLD);
  localparam bit                 ServeEn   = (SERVE_TIMEOUT != 0);
  localparam bit                 NeedTwo   = (WIN_BY_TWO != 0);

  state_e             r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_p1_score, w_p1_score_nxt;
  logic [SCORE_W-1:0] r_p2_score, w_p2_score_nxt;
  logic [1:0]         r_winner, w_winner_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic               r_launch, w_launch_nxt;
  logic               r_point_p1, w_point_p1_nxt;
  logic               r_point_p2, w_point_p2_nxt;

  logic               w_p1_btn, w_p2_btn, w_server_btn, w_timeout;
  logic [TMR_W-1:0]   w_timer_inc;
  logic [SCORE_W-1:0] w_p1_inc, w_p2_inc;
  logic               w_p1_win, w_p2_win;

  assign w_p1_btn     = i_p1l | i_p1r;
  assign w_p2_btn     = i_p2l | i_p2r;
  assign w_server_btn = (r_state == StP1Serve) ? w_p1_btn : w_p2_btn;
  assign w_timeout    = ServeEn && (r_timer == ServeLast);
  assign w_timer_inc  = (r_timer == TmrMax) ? r_timer : r_timer + TmrOne;
  assign w_p1_inc     = (r_p1_score == ScoreMax) ? r_p1_score : r_p1_score + ScoreOne;
  assign w_p2_inc     = (r_p2_score == ScoreMax) ? r_p2_score : r_p2_score + ScoreOne;

  // The saturated score can no longer progress, so reaching it ends the match regardless of margin
  assign w_p1_win = (({1'b0, w_p1_inc} >= WinScore) &&
                     (!NeedTwo || ({1'b0, w_p1_inc} >= {1'b0, r_p2_score} + ScoreTwo))) ||
                    (w_p1_inc == ScoreMax);
  assign w_p2_win = (({1'b0, w_p2_inc} >= WinScore) &&
                     (!NeedTwo || ({1'b0, w_p2_inc} >= {1'b0, r_p1_score} + ScoreTwo))) ||
                    (w_p2_inc == ScoreMax);

  // Next-state, score, timer and pulse decisions, taken only on frame ticks
  always_comb begin
    w_state_nxt    = r_state;
    w_p1_score_nxt = r_p1_score;
    w_p2_score_nxt = r_p2_score;
    w_winner_nxt   = r_winner;
    w_timer_nxt    = r_timer;
    w_launch_nxt   = 1'b0;
    w_point_p1_nxt = 1'b0;
    w_point_p2_nxt = 1'b0;
    if (i_frame_tick) begin
      unique case (r_state)
        StP1Serve, StP2Serve: begin
          if (w_server_btn || w_timeout) begin
            w_state_nxt  = StPlay;
            w_launch_nxt = 1'b1;
            w_timer_nxt  = '0;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
        StPlay: begin
          if (i_ball_x > RightGoal) begin
            w_p1_score_nxt = w_p1_inc;
            w_point_p1_nxt = 1'b1;
            w_timer_nxt    = '0;
            if (w_p1_win) begin
              w_state_nxt  = StEnd;
              w_winner_nxt = 2'd1;
            end else begin
              w_state_nxt = StP2Serve;
            end
          end else if (i_ball_x < LeftGoal) begin
            w_p2_score_nxt = w_p2_inc;
            w_point_p2_nxt = 1'b1;
            w_timer_nxt    = '0;
            if (w_p2_win) begin
              w_state_nxt  = StEnd;
              w_winner_nxt = 2'd2;
            end else begin
              w_state_nxt = StP1Serve;
            end
          end
        end
        StEnd: begin
          w_timer_nxt = w_timer_inc;
          if ((r_timer >= EndHold) && (w_p1_btn || w_p2_btn)) begin
            w_p1_score_nxt = '0;
            w_p2_score_nxt = '0;
            w_winner_nxt   = 2'd0;
            w_timer_nxt    = '0;
            // Loser serves the next match
            w_state_nxt    = (r_winner == 2'd1) ? StP2Serve : StP1Serve;
          end
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StP1Serve;
      r_p1_score <= '0;
      r_p2_score <= '0;
      r_winner   <= 2'd0;
      r_timer    <= '0;
      r_launch   <= 1'b0;
      r_point_p1 <= 1'b0;
      r_point_p2 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_p1_score <= w_p1_score_nxt;
      r_p2_score <= w_p2_score_nxt;
      r_winner   <= w_winner_nxt;
      r_timer    <= w_timer_nxt;
      r_launch   <= w_launch_nxt;
      r_point_p1 <= w_point_p1_nxt;
      r_point_p2 <= w_point_p2_nxt;
    end
  end

  assign o_game_state   = r_state;
  assign o_p1_score     = r_p1_score;
  assign o_p2_score     = r_p2_score;
  assign o_winner       = r_winner;
  assign o_frame_timer  = r_timer;
  assign o_serve_launch = r_launch;
  assign o_point_p1     = r_point_p1;
  assign o_point_p2     = r_point_p2;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: two instances (default rules, and first-to-11 with no auto-serve)
// share stimulus and are compared each cycle against a rule-level reference model.
module tb_pong_match_ctrl;

  logic       clk, rst_n, tick, p1l, p1r, p2l, p2r;
  logic [9:0] ball_x;

  logic [1:0] a_state, b_state, a_win, b_win;
  logic [3:0] a_s1, a_s2, b_s1, b_s2;
  logic       a_launch, a_pt1, a_pt2, b_launch, b_pt1, b_pt2;
  logic [7:0] a_tmr, b_tmr;

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = instance A, 1 = instance B
  int m_state [2];
  int m_s1    [2];
  int m_s2    [2];
  int m_win   [2];
  int m_tmr   [2];
  int m_launch[2];
  int m_pt1   [2];
  int m_pt2   [2];
  int p_wbt   [2] = '{1, 0};
  int p_to    [2] = '{60, 0};

  pong_match_ctrl u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_frame_tick(tick),
    .i_p1l(p1l), .i_p1r(p1r), .i_p2l(p2l), .i_p2r(p2r), .i_ball_x(ball_x),
    .o_game_state(a_state), .o_p1_score(a_s1), .o_p2_score(a_s2),
    .o_serve_launch(a_launch), .o_point_p1(a_pt1), .o_point_p2(a_pt2),
    .o_winner(a_win), .o_frame_timer(a_tmr)
  );

  pong_match_ctrl #(.WIN_BY_TWO(0), .SERVE_TIMEOUT(0)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_frame_tick(tick),
    .i_p1l(p1l), .i_p1r(p1r), .i_p2l(p2l), .i_p2r(p2r), .i_ball_x(ball_x),
    .o_game_state(b_state), .o_p1_score(b_s1), .o_p2_score(b_s2),
    .o_serve_launch(b_launch), .o_point_p1(b_pt1), .o_point_p2(b_pt2),
    .o_winner(b_win), .o_frame_timer(b_tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_win[k] = 0; m_tmr[k] = 0;
      m_launch[k] = 0; m_pt1[k] = 0; m_pt2[k] = 0;
    end
  endtask

  task automatic model_point(input int k, input int who);
    int me, opp;
    me  = (who == 1) ? m_s1[k] : m_s2[k];
    opp = (who == 1) ? m_s2[k] : m_s1[k];
    me  = (me + 1 > 15) ? 15 : me + 1;
    if (who == 1) begin m_s1[k] = me; m_pt1[k] = 1; end
    else          begin m_s2[k] = me; m_pt2[k] = 1; end
    m_tmr[k] = 0;
    if ((me >= 11 && (p_wbt[k] == 0 || me >= opp + 2)) || me == 15) begin
      m_state[k] = 3;
      m_win[k]   = who;
    end else begin
      m_state[k] = (who == 1) ? 1 : 0;  // conceding player serves
    end
  endtask

  task automatic model_tick(input int k, input bit b1, input bit b2, input int x);
    m_launch[k] = 0; m_pt1[k] = 0; m_pt2[k] = 0;
    if (m_state[k] <= 1) begin
      if (((m_state[k] == 0) ? b1 : b2) || (p_to[k] != 0 && m_tmr[k] == p_to[k] - 1)) begin
        m_state[k] = 2; m_launch[k] = 1; m_tmr[k] = 0;
      end else begin
        m_tmr[k] = (m_tmr[k] == 255) ? 255 : m_tmr[k] + 1;
      end
    end else if (m_state[k] == 2) begin
      if (x > 490)      model_point(k, 1);
      else if (x < 150) model_point(k, 2);
    end else begin
      if (m_tmr[k] >= 120 && (b1 || b2)) begin
        m_state[k] = (m_win[k] == 1) ? 1 : 0;
        m_s1[k] = 0; m_s2[k] = 0; m_win[k] = 0; m_tmr[k] = 0;
      end else begin
        m_tmr[k] = (m_tmr[k] == 255) ? 255 : m_tmr[k] + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("A.state",  a_state,  m_state[0]);  chk("B.state",  b_state,  m_state[1]);
    chk("A.p1",     a_s1,     m_s1[0]);     chk("B.p1",     b_s1,     m_s1[1]);
    chk("A.p2",     a_s2,     m_s2[0]);     chk("B.p2",     b_s2,     m_s2[1]);
    chk("A.winner", a_win,    m_win[0]);    chk("B.winner", b_win,    m_win[1]);
    chk("A.timer",  a_tmr,    m_tmr[0]);    chk("B.timer",  b_tmr,    m_tmr[1]);
    chk("A.launch", a_launch, m_launch[0]); chk("B.launch", b_launch, m_launch[1]);
    chk("A.pt1",    a_pt1,    m_pt1[0]);    chk("B.pt1",    b_pt1,    m_pt1[1]);
    chk("A.pt2",    a_pt2,    m_pt2[0]);    chk("B.pt2",    b_pt2,    m_pt2[1]);
  endtask

  // One frame: a tick cycle followed by a quiet cycle, both fully checked
  task automatic do_tick(input bit b1l, input bit b1r, input bit b2l, input bit b2r, input int x);
    @(negedge clk);
    p1l = b1l; p1r = b1r; p2l = b2l; p2r = b2r; ball_x = 10'(x); tick = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) model_tick(k, b1l | b1r, b2l | b2r, x);
    check_all();
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin m_launch[k] = 0; m_pt1[k] = 0; m_pt2[k] = 0; end
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic serve_point(input int who);
    do_tick(1, 1, 1, 1, 300);
    do_tick(0, 0, 0, 0, (who == 1) ? 491 : 149);
  endtask

  initial begin
    int r, x;
    bit q1l, q1r, q2l, q2r;
    rst_n = 1'b0; tick = 1'b0; p1l = 1'b0; p1r = 1'b0; p2l = 1'b0; p2r = 1'b0; ball_x = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Button serve on the third tick
    do_tick(0, 0, 0, 0, 300);
    do_tick(0, 0, 0, 0, 300);
    do_tick(1, 0, 0, 0, 300);
    chk("serve_btn_state", a_state, 2);

    // Goal-line boundaries
    do_tick(0, 0, 0, 0, 490);
    do_tick(0, 0, 0, 0, 150);
    do_tick(0, 0, 0, 0, 491);
    chk("goal_right_score", a_s1, 1);
    chk("goal_right_state", a_state, 1);
    do_tick(0, 0, 0, 1, 300);
    do_tick(0, 0, 0, 0, 149);
    chk("goal_left_score", a_s2, 1);
    chk("goal_left_state", a_state, 0);

    // Auto-serve on A at tick 60; B never auto-serves and its timer saturates
    repeat (59) do_tick(0, 0, 0, 0, 300);
    chk("timeout_pre_timer", a_tmr, 59);
    do_tick(0, 0, 0, 0, 300);
    chk("timeout_launch_state", a_state, 2);
    repeat (240) do_tick(0, 0, 0, 0, 300);
    chk("noauto_state", b_state, 0);
    chk("noauto_timer_sat", b_tmr, 255);

    // Win by two versus first to eleven, then end-state hold
    do_reset();
    for (int i = 0; i < 10; i++) begin serve_point(1); serve_point(2); end
    serve_point(1);
    chk("wbt_11_10_state", a_state, 1);
    chk("first11_state", b_state, 3);
    chk("first11_winner", b_win, 1);
    serve_point(1);
    chk("wbt_12_10_state", a_state, 3);
    chk("wbt_12_10_winner", a_win, 1);
    repeat (120) do_tick(1, 1, 1, 1, 300);
    chk("hold_state", a_state, 3);
    chk("hold_timer", a_tmr, 120);
    do_tick(1, 1, 1, 1, 300);
    chk("release_state", a_state, 1);
    chk("release_score", a_s1, 0);

    // Deuce to 14-14, then saturation forces the win
    do_reset();
    for (int i = 0; i < 14; i++) begin serve_point(1); serve_point(2); end
    chk("deuce_p1", a_s1, 14);
    serve_point(2);
    chk("sat_state", a_state, 3);
    chk("sat_winner", a_win, 2);
    chk("sat_p2", a_s2, 15);

    // Reset mid-rally clears the launch pulse without waiting for a clock edge
    do_reset();
    @(negedge clk);
    p1l = 1'b1; tick = 1'b1; ball_x = 10'd300;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) model_tick(k, 1'b1, 1'b0, 300);
    check_all();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1; tick = 1'b0; p1l = 1'b0;
    do_tick(0, 0, 0, 0, 300);

    // Randomised play
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      r = $urandom_range(0, 2);
      if (r == 0)      x = $urandom_range(491, 1023);
      else if (r == 1) x = $urandom_range(0, 149);
      else             x = $urandom_range(150, 490);
      q1l = ($urandom_range(0, 7) == 0); q1r = ($urandom_range(0, 7) == 0);
      q2l = ($urandom_range(0, 7) == 0); q2r = ($urandom_range(0, 7) == 0);
      do_tick(q1l, q1r, q2l, q2r, x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
